// File: rtl/nn_result_axis_tx.sv
// AXI4-Stream transmitter for the final-layer result vector (plus optional class beat).
// Holds one frame in transmission and one pending vector; later vectors are dropped and counted.
module nn_result_axis_tx #(
    parameter int NN           = 10,
    parameter int dataWidth    = 16,
    parameter int APPEND_CLASS = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_valid,
    input  logic [NN*dataWidth-1:0]   i_data,
    input  logic [31:0]               i_class,
    output logic [dataWidth-1:0]      m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic                      o_busy,
    output logic                      o_overflow,
    output logic [7:0]                o_drop_count
);
    localparam int L  = NN + ((APPEND_CLASS != 0) ? 1 : 0);
    localparam int CW = (L > 1) ? $clog2(L) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(L - 1);
    localparam logic [CW-1:0] CLS_IDX  = CW'(NN);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]              state;
    logic [CW-1:0]           cnt;
    logic [NN*dataWidth-1:0] act_data, pend_data;
    logic [dataWidth-1:0]    act_cls, pend_cls, cls_in, beat;
    logic                    pend_full;
    logic                    xfer, last_xfer;

    // Class index is narrowed or zero-extended to one stream beat at capture time.
    generate
        if (dataWidth < 32) begin : g_cls_narrow
            logic unused_cls_hi;
            assign unused_cls_hi = ^i_class[31:dataWidth];
            assign cls_in = i_class[dataWidth-1:0];
        end else if (dataWidth == 32) begin : g_cls_eq
            assign cls_in = i_class;
        end else begin : g_cls_wide
            assign cls_in = {{(dataWidth-32){1'b0}}, i_class};
        end
    endgenerate

    assign m_axis_tvalid = (state == SEND);
    assign m_axis_tlast  = (state == SEND) && (cnt == LAST_IDX);
    assign xfer          = m_axis_tvalid && m_axis_tready;
    assign last_xfer     = xfer && (cnt == LAST_IDX);
    assign o_busy        = (state == SEND) || pend_full;

    always_comb begin
        beat = '0;
        for (int k = 0; k < NN; k++)
            if (cnt == CW'(k)) beat = act_data[k*dataWidth +: dataWidth];
        if (APPEND_CLASS != 0 && cnt == CLS_IDX) beat = act_cls;
    end

    // Output forced to zero outside a frame so idle/reset data is deterministic.
    assign m_axis_tdata = m_axis_tvalid ? beat : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            act_data     <= '0;
            act_cls      <= '0;
            pend_data    <= '0;
            pend_cls     <= '0;
            pend_full    <= 1'b0;
            o_overflow   <= 1'b0;
            o_drop_count <= 8'd0;
        end else if (state == IDLE) begin
            if (i_valid) begin
                act_data <= i_data;
                act_cls  <= cls_in;
                cnt      <= '0;
                state    <= SEND;
            end
        end else if (last_xfer) begin
            cnt <= '0;
            if (pend_full) begin
                act_data <= pend_data;
                act_cls  <= pend_cls;
                if (i_valid) begin
                    pend_data <= i_data;
                    pend_cls  <= cls_in;
                end else begin
                    pend_full <= 1'b0;
                end
            end else if (i_valid) begin
                act_data <= i_data;
                act_cls  <= cls_in;
            end else begin
                state <= IDLE;
            end
        end else begin
            if (xfer) cnt <= cnt + CW'(1);
            if (i_valid) begin
                if (!pend_full) begin
                    pend_data <= i_data;
                    pend_cls  <= cls_in;
                    pend_full <= 1'b1;
                end else begin
                    o_overflow <= 1'b1;
                    if (o_drop_count != 8'hFF) o_drop_count <= o_drop_count + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_nn_result_axis_tx.sv
// Directed bench for nn_result_axis_tx: scoreboard of expected beats, checked as the stream transfers.
module tb_nn_result_axis_tx;
    localparam int NN = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid, i_valid1;
    logic [NN*DW-1:0] i_data;
    logic [31:0]   i_class;
    logic [DW-1:0] tdata, tdata1;
    logic          tvalid, tvalid1, tready, tready1, tlast, tlast1;
    logic          busy, busy1, ovf, ovf1;
    logic [7:0]    dropc, dropc1;

    int n_chk  = 0;
    int n_pass = 0;
    logic [DW:0] q[$];
    logic [DW:0] q1[$];

    always #5 clk = ~clk;

    nn_result_axis_tx #(.NN(NN), .dataWidth(DW), .APPEND_CLASS(1)) u0 (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .i_class(i_class),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .m_axis_tlast(tlast), .o_busy(busy), .o_overflow(ovf), .o_drop_count(dropc));

    nn_result_axis_tx #(.NN(NN), .dataWidth(DW), .APPEND_CLASS(0)) u1 (
        .clk(clk), .rst(rst), .i_valid(i_valid1), .i_data(i_data), .i_class(i_class),
        .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1), .m_axis_tready(tready1),
        .m_axis_tlast(tlast1), .o_busy(busy1), .o_overflow(ovf1), .o_drop_count(dropc1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NN*DW-1:0] mkvec(input logic [DW-1:0] base);
        logic [NN*DW-1:0] v;
        for (int k = 0; k < NN; k++) v[k*DW +: DW] = base + DW'(k);
        return v;
    endfunction

    // Drive a one-cycle i_valid pulse on u0; expected beats queued only if the vector is to be kept.
    task automatic send(input logic [NN*DW-1:0] d, input logic [31:0] c, input bit keep);
        i_valid = 1'b1; i_data = d; i_class = c;
        if (keep) begin
            for (int k = 0; k < NN; k++) q.push_back({1'b0, d[k*DW +: DW]});
            q.push_back({1'b1, c[DW-1:0]});
        end
        tick();
        i_valid = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (q.size() == 0 && !tvalid) break;
            tick();
        end
        chk(tag, {31'd0, (q.size() == 0 && !tvalid)}, 32'd1);
    endtask

    // Stream monitor for u0: transfer checking plus hold-stable checks during stalls.
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic [DW:0]   e;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", {31'd0, tvalid}, 32'd1);
                chk("hold_data", {16'd0, tdata}, {16'd0, prev_data});
                chk("hold_last", {31'd0, tlast}, {31'd0, prev_last});
            end
            if (tvalid && tready) begin
                chk("beat_expected", {31'd0, (q.size() != 0)}, 32'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("beat_data", {16'd0, tdata}, {16'd0, e[DW-1:0]});
                    chk("beat_last", {31'd0, tlast}, {31'd0, e[DW]});
                end
            end
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            prev_last  = tlast;
        end
    end

    logic [DW:0] e1;
    always @(negedge clk) begin
        if (!rst && tvalid1 && tready1) begin
            chk("u1_beat_expected", {31'd0, (q1.size() != 0)}, 32'd1);
            if (q1.size() != 0) begin
                e1 = q1.pop_front();
                chk("u1_beat_data", {16'd0, tdata1}, {16'd0, e1[DW-1:0]});
                chk("u1_beat_last", {31'd0, tlast1}, {31'd0, e1[DW]});
            end
        end
    end

    initial begin
        logic [NN*DW-1:0] va, vb, vc;
        rst = 1'b1; i_valid = 1'b0; i_valid1 = 1'b0; i_data = '0; i_class = '0;
        tready = 1'b1; tready1 = 1'b1;
        tick(); tick();
        chk("rst_tvalid", {31'd0, tvalid}, 32'd0);
        chk("rst_tlast", {31'd0, tlast}, 32'd0);
        chk("rst_tdata", {16'd0, tdata}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_drop", {24'd0, dropc}, 32'd0);
        rst = 1'b0;
        tick();

        // 1: single frame, latency 1, five beats, tlast on class beat
        va = mkvec(16'h0001);
        chk("t1_idle_valid", {31'd0, tvalid}, 32'd0);
        send(va, 32'd2, 1'b1);
        chk("t1_latency_valid", {31'd0, tvalid}, 32'd1);
        chk("t1_beat0", {16'd0, tdata}, 32'h0001);
        drain("t1_drain", 20);
        chk("t1_idle_after", {31'd0, busy}, 32'd0);

        // 2: backpressure with tready 1,0,0 repeating
        send(va, 32'd2, 1'b1);
        for (int i = 0; i < 40; i++) begin
            if (q.size() == 0 && !tvalid) break;
            tready = (i % 3 == 0);
            tick();
        end
        tready = 1'b1;
        drain("t2_drain", 5);

        // 3: back-to-back frames with second vector arriving during beat 2
        vb = mkvec(16'h0011);
        send(va, 32'd2, 1'b1);
        tick();
        tick();
        chk("t3_beat2", {16'd0, tdata}, 32'h0003);
        send(vb, 32'd7, 1'b1);
        chk("t3_busy_b3", {31'd0, busy}, 32'd1);
        tick();
        chk("t3_f1_last", {31'd0, tlast}, 32'd1);
        chk("t3_busy_b4", {31'd0, busy}, 32'd1);
        tick();
        chk("t3_no_bubble", {31'd0, tvalid}, 32'd1);
        chk("t3_f2_beat0", {16'd0, tdata}, 32'h0011);
        chk("t3_busy_f2", {31'd0, busy}, 32'd1);
        drain("t3_drain", 20);

        // 4: overflow with stalled consumer
        tready = 1'b0;
        vc = mkvec(16'h0021);
        send(va, 32'd1, 1'b1);
        send(vb, 32'd3, 1'b1);
        send(vc, 32'd5, 1'b0);
        chk("t4_ovf", {31'd0, ovf}, 32'd1);
        chk("t4_drop", {24'd0, dropc}, 32'd1);
        chk("t4_busy", {31'd0, busy}, 32'd1);
        tready = 1'b1;
        drain("t4_drain_two_frames", 30);
        chk("t4_ovf_sticky", {31'd0, ovf}, 32'd1);

        // 5: reset during beat 2
        send(va, 32'd2, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        q.delete();
        tick();
        rst = 1'b0;
        chk("t5_tvalid", {31'd0, tvalid}, 32'd0);
        chk("t5_tlast", {31'd0, tlast}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_ovf", {31'd0, ovf}, 32'd0);
        chk("t5_drop", {24'd0, dropc}, 32'd0);
        tick();
        send(vb, 32'd9, 1'b1);
        chk("t5_clean_beat0", {16'd0, tdata}, 32'h0011);
        drain("t5_drain", 20);

        // 6: APPEND_CLASS=0 build, 4 beats with tlast on beat 0004
        i_valid1 = 1'b1; i_data = va; i_class = 32'd2;
        for (int k = 0; k < NN; k++) q1.push_back({(k == NN-1), va[k*DW +: DW]});
        tick();
        i_valid1 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (q1.size() == 0 && !tvalid1) break;
            tick();
        end
        chk("t6_drain", {31'd0, (q1.size() == 0 && !tvalid1)}, 32'd1);
        chk("t6_u0_quiet", {31'd0, tvalid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/nn_result_axis_tx.md
Name: nn_result_axis_tx

Overview:
- AXI4-Stream master transmitter for the final-layer result of the neural-network pipeline.
- Captures the parallel output vector of the last Layer, plus the class index from maxFinder.
- Serializes them as one stream frame with full valid/ready backpressure and TLAST.
- Replaces register-polled result readout with a streaming path toward a DMA or downstream consumer.

Parameters:
NN, 10, number of neurons in the final layer (data beats per frame)
dataWidth, 16, width of one neuron output and of m_axis_tdata
APPEND_CLASS, 1, 1 = append one extra beat carrying the class index after the NN data beats; 0 = no class beat

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
i_valid  input  1  single-cycle strobe: i_data/i_class valid (driven by o_valid[0] of last Layer)
i_data  input  NN*dataWidth  final-layer outputs, neuron 0 in bits [dataWidth-1:0]
i_class  input  32  winning-class index from maxFinder, sampled with i_valid
m_axis_tdata  output  dataWidth  stream data
m_axis_tvalid  output  1  stream valid
m_axis_tready  input  1  stream ready from consumer
m_axis_tlast  output  1  high on final beat of frame
o_busy  output  1  high while a frame is active or pending
o_overflow  output  1  sticky: a result vector was dropped
o_drop_count  output  8  saturating count of dropped vectors

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - tvalid=0, tlast=0, tdata=0, o_busy=0, o_overflow=0, o_drop_count=0.
  - Active and pending buffers cleared.
  - Reset mid-frame abandons the frame: tvalid low the next cycle, no TLAST emitted.
- Frame length L = NN + APPEND_CLASS beats.
  - Beat k (0..NN-1) = i_data[k*dataWidth +: dataWidth].
  - Class beat = i_class[dataWidth-1:0]; zero-extended if dataWidth > 32.
- Storage: one active buffer (frame in transmission) and one pending buffer (next full vector).
- State machine, states IDLE and SEND:
  - IDLE: tvalid=0. On i_valid, load active, set beat counter=0, go to SEND. tvalid=1 with beat 0 on the next cycle (latency 1 clock).
  - SEND: tvalid=1; tdata = current beat; tlast = (counter == L-1).
    - A transfer occurs when tvalid && tready. On transfer, counter increments and tdata advances to the next beat on the next cycle.
  - Last-beat transfer, pending full: move pending into active, counter=0, stay in SEND. Beat 0 of the next frame is presented the very next cycle, with no bubble.
  - Last-beat transfer, pending empty, no i_valid that cycle: go to IDLE.
- AXIS rule: while tvalid && !tready, tdata and tlast are held stable. tvalid never drops mid-frame except on reset.
- Capture rules on i_valid:
  - IDLE: load active.
  - SEND with pending empty: load pending. If the same cycle is the last-beat transfer, load active directly instead (back-to-back, no bubble).
  - SEND with pending full: if the same cycle is the last-beat transfer, pending moves to active and the new vector goes to pending.
  - SEND with pending full, otherwise: drop the new vector. Set o_overflow (sticky until rst). Increment o_drop_count, saturating at 255.
- o_busy = (state==SEND) || pending full.
- Counter width: clog2(L), minimum 1 bit.

Test Plan:
(Bench parameters: NN=4, dataWidth=16, APPEND_CLASS=1.)
1. Single frame, tready=1: i_valid with i_data={16'h0004,16'h0003,16'h0002,16'h0001}, i_class=2.
   - Expect tvalid 1 cycle later.
   - Beats 0001,0002,0003,0004,0002 on consecutive cycles.
   - tlast only on the 5th beat, then tvalid=0.
2. Backpressure: same frame, tready toggling 1,0,0,1,...
   - Expect tdata/tlast stable during stalls.
   - Same 5-beat sequence, no duplicates or losses.
3. Back-to-back: second i_valid (vector 0x0011..0x0014, class 7) during beat 2 of frame 1, tready=1.
   - Expect frame 2 beat 0011 in the cycle after frame 1's tlast beat, with no bubble.
   - o_busy high throughout.
4. Overflow: tready=0, issue three i_valid pulses.
   - First is active, second pending, third dropped.
   - Expect o_overflow=1 and o_drop_count=1.
   - After tready=1, exactly two frames (10 beats) are emitted.
5. Reset mid-frame: assert rst during beat 2 with tready=1.
   - Expect tvalid=0 next cycle, no tlast, all status outputs 0.
   - A subsequent i_valid produces a clean frame starting at beat 0.
6. APPEND_CLASS=0 build: expect 4-beat frames with tlast on beat 0004.
